dyn_console_writer: RTL and testbench
=====================================

# dyn_console_writer

Write-side companion of the dynamic text console. Accepts a character stream over a valid/ready handshake, maintains a text cursor, and issues single-cycle writes into the video RAM. Cells use the same row-major map the display pipeline uses to read characters (addr = row·screenW + col). Also handles carriage return, line feed, backspace and a hardware screen clear; cursor position is exported for a cursor-overlay stage.

## Interface

Parameters:
- size, 16, glyph size in pixels; must be a power of 2.
- screenW, 640/size, text columns (40 at default).
- screenH, 480/size, text rows (30 at default).

Ports:
- px_clk  in  1  pixel clock; sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- char_i  in  8  character code (ASCII).
- char_valid_i  in  1  char_i valid.
- char_ready_o  out  1  block can accept char_i this cycle.
- clear_i  in  1  request full-screen clear (level, sampled).
- addr_wr  out  13  VRAM write address.
- data_wr  out  8  VRAM write data.
- we_wr  out  1  VRAM write strobe, one cycle per write.
- cursor_col  out  10  current cursor column.
- cursor_row  out  10  current cursor row.
- busy_o  out  1  clear in progress.

## Operation

- Reset: state IDLE; cursor_col=0, cursor_row=0, addr_wr=0, data_wr=0, we_wr=0, busy_o=0; char_ready_o forced 0 while rst_n low.
- States: IDLE, CLEAR.
- char_ready_o = (state==IDLE) && !clear_i && rst_n; combinational.
- Accept = char_valid_i && char_ready_o at a px_clk edge. At most one char per cycle; back-to-back accepts allowed.
- Printable (0x20–0x7E): write char at (row,col), then advance col. If col==screenW-1: col→0, row+1. If row==screenH-1 too: row→0 (wrap to top, no scroll).
- 0x0D CR: col→0, no write.
- 0x0A LF: col→0, row+1 (row screenH-1 wraps to 0), no write.
- 0x08 BS: if col>0, col−1 and write 0x20 at the new position. If col==0, no-op.
- 0x0C FF: identical to a clear request.
- Any other code: consumed, no write, cursor unchanged.
- Clear: clear_i high in IDLE (priority over a simultaneous char_valid_i, which is not consumed) or FF accepted. Result: 0x20 is written to addresses 0 … screenW·screenH−1 in ascending order, one per cycle; cursor home. clear_i during CLEAR is ignored.
- Address arithmetic: row·screenW + col computed at full 13-bit width. Maximum 1199 at default; screenW·screenH must be ≤ 8192.

## Timing

- Write latency: accept at edge N → we_wr=1 with addr_wr/data_wr valid for exactly the cycle after edge N. Cursor outputs update at edge N.
- we_wr low in every cycle without a write. addr_wr/data_wr hold their last value.
- Clear accepted at edge N: cursor→0,0 at edge N; writes for addresses 0..C−1 (C=screenW·screenH) are presented in C consecutive cycles starting after edge N. State is CLEAR, busy_o=1 and char_ready_o=0 from edge N until edge N+C−1. char_ready_o is high again in the cycle presenting address C−1, so a char accepted then writes the next cycle with no gap or overlap.
- Reset mid-clear: immediate abort to reset values. VRAM is left partially cleared; the clear is not resumed.

## Structure

- Shared package console_pkg: SIZE, SCREEN_W, SCREEN_H, CELLS, address width (13), control-code constants (CR, LF, BS, FF, SPACE), state encoding.
- One sub-module: console_cell_addr, combinational (row, col) → 13-bit address. The display-side address stage uses the same module, so read and write maps stay identical.

## Test plan

- Reset then char 0x41 → one cycle after accept: we_wr=1, addr_wr=0, data_wr=0x41; cursor_col=1.
- 40 printable chars from home → last write addr 39; cursor (row1,col0); next char written at addr 40.
- Cursor (29,39) + 0x42 → write addr 1199; cursor wraps to (0,0). Cursor (29,5) + LF → cursor (0,0), no write.
- BS at (2,5) → write 0x20 at addr 84, cursor (2,4). BS at (2,0) → no write, cursor unchanged.
- clear_i and char_valid_i high together at cursor (3,3) → char not consumed; 1200 consecutive writes of 0x20 to addrs 0–1199; busy_o high for 1199 cycles; cursor (0,0); the pending char then writes to addr 0.
- rst_n low at clear write 500 → we_wr=0 at once, all outputs at reset values; after release, char 0x41 writes to addr 0.

Source files
------------

// File: rtl/console_pkg.sv
// Shared console constants, control codes, FSM encoding and the VRAM write payload.
package console_pkg;

  localparam int unsigned SIZE     = 16;
  localparam int unsigned SCREEN_W = 640 / SIZE;
  localparam int unsigned SCREEN_H = 480 / SIZE;
  localparam int unsigned CELLS    = SCREEN_W * SCREEN_H;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CHAR_W   = 8;

  localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;
  localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_FF    = 8'h0C;
  localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] CH_TILDE = 8'h7E;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] data;
  } vram_wr_t;

  // Codes that produce a glyph write (space through tilde).
  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/console_cell_addr.sv
// Row-major cell address: addr = row * screenW + col, full 13-bit arithmetic.
// Ports: row, col (cursor coordinates) -> addr_c (combinational VRAM address).
module console_cell_addr
  import console_pkg::*;
#(
  parameter int unsigned screenW = SCREEN_W
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [ADDR_W-1:0]  addr_c
);

  assign addr_c = ADDR_W'(row) * ADDR_W'(screenW) + ADDR_W'(col);

endmodule

// File: rtl/dyn_console_writer.sv
// Character-stream writer for the text console: cursor tracking, control codes,
// single-cycle VRAM writes and a sequential full-screen clear.
// Ports: px_clk/rst_n; char_i/char_valid_i/char_ready_o handshake; clear_i;
//        addr_wr/data_wr/we_wr VRAM write port; cursor_col/cursor_row; busy_o.
module dyn_console_writer
  import console_pkg::*;
#(
  parameter int unsigned size    = SIZE,
  parameter int unsigned screenW = 640 / size,
  parameter int unsigned screenH = 480 / size
) (
  input  logic                px_clk,
  input  logic                rst_n,
  input  logic [CHAR_W-1:0]   char_i,
  input  logic                char_valid_i,
  output logic                char_ready_o,
  input  logic                clear_i,
  output logic [ADDR_W-1:0]   addr_wr,
  output logic [CHAR_W-1:0]   data_wr,
  output logic                we_wr,
  output logic [COORD_W-1:0]  cursor_col,
  output logic [COORD_W-1:0]  cursor_row,
  output logic                busy_o
);

  localparam int unsigned CELLS_L = screenW * screenH;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   col_d, row_d, row_next_c, addr_col_c;
  logic [ADDR_W-1:0]    cell_addr_c;
  vram_wr_t             wr_d;
  logic                 we_d, busy_d, accept_c;

  assign char_ready_o = (state_q == ST_IDLE) && !clear_i && rst_n;
  assign accept_c     = char_valid_i && char_ready_o;

  // Backspace writes at the column to the left of the cursor.
  assign addr_col_c = (char_i == CH_BS) ? cursor_col - COORD_W'(1) : cursor_col;
  assign row_next_c = (cursor_row == COORD_W'(screenH - 1)) ? '0 : cursor_row + COORD_W'(1);

  console_cell_addr #(.screenW(screenW)) u_cell_addr (
    .row    (cursor_row),
    .col    (addr_col_c),
    .addr_c (cell_addr_c)
  );

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d = state_q;
    col_d   = cursor_col;
    row_d   = cursor_row;
    wr_d    = '{addr: addr_wr, data: data_wr};
    we_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i || (accept_c && char_i == CH_FF)) begin
          state_d = ST_CLEAR;
          col_d   = '0;
          row_d   = '0;
          wr_d    = '{addr: '0, data: CH_SPACE};
          we_d    = 1'b1;
        end else if (accept_c) begin
          if (is_printable(char_i)) begin
            wr_d = '{addr: cell_addr_c, data: char_i};
            we_d = 1'b1;
            if (cursor_col == COORD_W'(screenW - 1)) begin
              col_d = '0;
              row_d = row_next_c;
            end else begin
              col_d = cursor_col + COORD_W'(1);
            end
          end else if (char_i == CH_CR) begin
            col_d = '0;
          end else if (char_i == CH_LF) begin
            col_d = '0;
            row_d = row_next_c;
          end else if (char_i == CH_BS && cursor_col != '0) begin
            col_d = addr_col_c;
            wr_d  = '{addr: cell_addr_c, data: CH_SPACE};
            we_d  = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        // Leave CLEAR on the edge that presents the last cell so input reopens then.
        wr_d = '{addr: addr_wr + ADDR_W'(1), data: CH_SPACE};
        we_d = 1'b1;
        if (addr_wr == ADDR_W'(CELLS_L - 2)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // State and registered outputs.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cursor_col <= '0;
      cursor_row <= '0;
      addr_wr    <= '0;
      data_wr    <= '0;
      we_wr      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      addr_wr    <= wr_d.addr;
      data_wr    <= wr_d.data;
      we_wr      <= we_d;
      busy_o     <= busy_d;
    end
  end

endmodule

// File: tb/tb_dyn_console_writer.sv
// Directed self-checking bench for dyn_console_writer (default 40x30 geometry).
module tb_dyn_console_writer;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_i;
  logic        char_valid_i;
  logic        char_ready_o;
  logic        clear_i;
  logic [12:0] addr_wr;
  logic [7:0]  data_wr;
  logic        we_wr;
  logic [9:0]  cursor_col;
  logic [9:0]  cursor_row;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  dyn_console_writer dut (
    .px_clk       (px_clk),
    .rst_n        (rst_n),
    .char_i       (char_i),
    .char_valid_i (char_valid_i),
    .char_ready_o (char_ready_o),
    .clear_i      (clear_i),
    .addr_wr      (addr_wr),
    .data_wr      (data_wr),
    .we_wr        (we_wr),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .busy_o       (busy_o)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one character, wait (bounded) for ready, return #1 after the accepting edge.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge px_clk);
    char_i       = c;
    char_valid_i = 1'b1;
    while (!char_ready_o && n < 3000) begin
      @(negedge px_clk);
      n++;
    end
    if (!char_ready_o) check("ready_timeout", 32'(char_ready_o), 32'd1);
    @(posedge px_clk);
    #1;
    char_valid_i = 1'b0;
  endtask

  initial begin
    int bad_we, bad_addr, bad_data, busy_cnt;
    rst_n        = 1'b0;
    char_i       = 8'h00;
    char_valid_i = 1'b0;
    clear_i      = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    check("rst_we", 32'(we_wr), 0);
    check("rst_addr", 32'(addr_wr), 0);
    check("rst_data", 32'(data_wr), 0);
    check("rst_col", 32'(cursor_col), 0);
    check("rst_row", 32'(cursor_row), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ready", 32'(char_ready_o), 0);
    @(negedge px_clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(char_ready_o), 1);

    // First printable char at home.
    send(8'h41);
    check("a_we", 32'(we_wr), 1);
    check("a_addr", 32'(addr_wr), 0);
    check("a_data", 32'(data_wr), 32'h41);
    check("a_col", 32'(cursor_col), 1);
    @(posedge px_clk); #1;
    check("a_we_drop", 32'(we_wr), 0);

    // CR: home column, no write.
    send(8'h0D);
    check("cr_we", 32'(we_wr), 0);
    check("cr_col", 32'(cursor_col), 0);

    // Full line of 40 chars from home.
    for (int i = 0; i < 40; i++) send(8'h61 + 8'(i % 26));
    check("line_addr", 32'(addr_wr), 39);
    check("line_row", 32'(cursor_row), 1);
    check("line_col", 32'(cursor_col), 0);
    send(8'h58);
    check("next_addr", 32'(addr_wr), 40);
    check("next_data", 32'(data_wr), 32'h58);

    // Walk to (29,39) then write the last cell.
    send(8'h0D);
    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 39; i++) send(8'h30);
    check("pre_row", 32'(cursor_row), 29);
    check("pre_col", 32'(cursor_col), 39);
    check("pre_addr", 32'(addr_wr), 1198);
    send(8'h42);
    check("last_we", 32'(we_wr), 1);
    check("last_addr", 32'(addr_wr), 1199);
    check("last_data", 32'(data_wr), 32'h42);
    check("wrap_row", 32'(cursor_row), 0);
    check("wrap_col", 32'(cursor_col), 0);

    // LF on the bottom row wraps to top.
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h31);
    check("lf_pre_col", 32'(cursor_col), 5);
    send(8'h0A);
    check("lf_we", 32'(we_wr), 0);
    check("lf_row", 32'(cursor_row), 0);
    check("lf_col", 32'(cursor_col), 0);

    // Backspace at (2,5) and at column 0.
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h32);
    send(8'h08);
    check("bs_we", 32'(we_wr), 1);
    check("bs_addr", 32'(addr_wr), 84);
    check("bs_data", 32'(data_wr), 32'h20);
    check("bs_col", 32'(cursor_col), 4);
    check("bs_row", 32'(cursor_row), 2);
    send(8'h0D);
    send(8'h08);
    check("bs0_we", 32'(we_wr), 0);
    check("bs0_col", 32'(cursor_col), 0);
    check("bs0_row", 32'(cursor_row), 2);

    // Unknown control code: consumed, nothing changes.
    send(8'h33);
    send(8'h01);
    check("ctl_we", 32'(we_wr), 0);
    check("ctl_col", 32'(cursor_col), 1);
    check("ctl_row", 32'(cursor_row), 2);

    // Move to (3,3), then clear_i with a pending char.
    send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h34);
    check("clr_pre_col", 32'(cursor_col), 3);
    check("clr_pre_row", 32'(cursor_row), 3);
    @(negedge px_clk);
    char_i       = 8'h5A;
    char_valid_i = 1'b1;
    clear_i      = 1'b1;
    #1;
    check("clr_ready_low", 32'(char_ready_o), 0);
    @(posedge px_clk); #1;
    clear_i = 1'b0;
    check("clr_col", 32'(cursor_col), 0);
    check("clr_row", 32'(cursor_row), 0);
    bad_we = 0; bad_addr = 0; bad_data = 0; busy_cnt = 0;
    for (int k = 0; k < 1200; k++) begin
      if (we_wr !== 1'b1) bad_we++;
      if (addr_wr !== 13'(k)) bad_addr++;
      if (data_wr !== 8'h20) bad_data++;
      if (busy_o === 1'b1) busy_cnt++;
      @(posedge px_clk); #1;
    end
    check("clr_bad_we", 32'(bad_we), 0);
    check("clr_bad_addr", 32'(bad_addr), 0);
    check("clr_bad_data", 32'(bad_data), 0);
    check("clr_busy_cycles", 32'(busy_cnt), 1199);
    check("pend_we", 32'(we_wr), 1);
    check("pend_addr", 32'(addr_wr), 0);
    check("pend_data", 32'(data_wr), 32'h5A);
    check("pend_col", 32'(cursor_col), 1);
    char_valid_i = 1'b0;

    // FF clear, reset at write 500.
    send(8'h0C);
    check("ff_busy", 32'(busy_o), 1);
    check("ff_addr", 32'(addr_wr), 0);
    check("ff_col", 32'(cursor_col), 0);
    for (int k = 0; k < 500; k++) begin
      @(posedge px_clk); #1;
    end
    check("ff_addr500", 32'(addr_wr), 500);
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(we_wr), 0);
    check("abort_addr", 32'(addr_wr), 0);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_ready", 32'(char_ready_o), 0);
    @(negedge px_clk);
    rst_n = 1'b1;
    send(8'h41);
    check("post_addr", 32'(addr_wr), 0);
    check("post_data", 32'(data_wr), 32'h41);
    check("post_busy", 32'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
